// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter that shares one pipelined 8-bit ALU among NREQ requesters.
// Each requester has at most one operation in flight; its result is held until accepted.
module alu_req_arbiter #(
    parameter int NREQ    = 4,
    parameter int ALU_LAT = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [8*NREQ-1:0]   req_a,
    input  logic [8*NREQ-1:0]   req_b,
    input  logic [3*NREQ-1:0]   req_op,
    output logic [NREQ-1:0]     rsp_valid,
    input  logic [NREQ-1:0]     rsp_ready,
    output logic [8*NREQ-1:0]   rsp_data,
    output logic [NREQ-1:0]     rsp_carry,
    output logic [7:0]          alu_a,
    output logic [7:0]          alu_b,
    output logic [2:0]          alu_op,
    input  logic [7:0]          alu_out,
    input  logic                alu_carry,
    output logic                busy
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]             pending_q, pending_d;
    logic [IDW-1:0]              last_grant_q, last_grant_d;
    logic [ALU_LAT-1:0]          tag_v_q, tag_v_d;
    logic [ALU_LAT-1:0][IDW-1:0] tag_id_q, tag_id_d;
    logic [NREQ-1:0]             rsp_valid_q, rsp_valid_d;
    logic [8*NREQ-1:0]           rsp_data_q, rsp_data_d;
    logic [NREQ-1:0]             rsp_carry_q, rsp_carry_d;

    logic [NREQ-1:0] eligible;
    logic [NREQ-1:0] grant;
    logic [NREQ-1:0] rsp_hs;
    logic            grant_any;
    logic [IDW-1:0]  grant_id;
    logic [IDW-1:0]  cand;
    logic            cap_v;
    logic [IDW-1:0]  cap_id;

    assign eligible = req_valid & ~pending_q;
    assign rsp_hs   = rsp_valid_q & rsp_ready;

    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        cand      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDW'((int'(last_grant_q) + k) % NREQ);
            if (!grant_any && eligible[cand]) begin
                grant_any = 1'b1;
                grant_id  = cand;
            end
        end
        // pending is already clear during reset, so the grant must be masked explicitly
        if (!rst_n) grant_any = 1'b0;
        grant = grant_any ? (NREQ'(1) << grant_id) : '0;
    end

    assign req_ready = grant;
    assign alu_a     = grant_any ? req_a[8*grant_id +: 8] : 8'h00;
    assign alu_b     = grant_any ? req_b[8*grant_id +: 8] : 8'h00;
    assign alu_op    = grant_any ? req_op[3*grant_id +: 3] : 3'b000;

    always_comb begin
        pending_d    = (pending_q | grant) & ~rsp_hs;
        last_grant_d = grant_any ? grant_id : last_grant_q;

        tag_v_d     = '0;
        tag_id_d    = '0;
        tag_v_d[0]  = grant_any;
        tag_id_d[0] = grant_id;
        for (int s = 1; s < ALU_LAT; s++) begin
            tag_v_d[s]  = tag_v_q[s-1];
            tag_id_d[s] = tag_id_q[s-1];
        end

        cap_v       = tag_v_q[ALU_LAT-1];
        cap_id      = tag_id_q[ALU_LAT-1];
        rsp_valid_d = rsp_valid_q & ~rsp_hs;
        rsp_data_d  = rsp_data_q;
        rsp_carry_d = rsp_carry_q;
        if (cap_v) begin
            rsp_valid_d[cap_id]          = 1'b1;
            rsp_data_d[8*cap_id +: 8]    = alu_out;
            rsp_carry_d[cap_id]          = alu_carry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q    <= '0;
            last_grant_q <= IDW'(NREQ - 1);
            tag_v_q      <= '0;
            tag_id_q     <= '0;
            rsp_valid_q  <= '0;
            rsp_data_q   <= '0;
            rsp_carry_q  <= '0;
        end else begin
            pending_q    <= pending_d;
            last_grant_q <= last_grant_d;
            tag_v_q      <= tag_v_d;
            tag_id_q     <= tag_id_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_carry_q  <= rsp_carry_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_carry = rsp_carry_q;
    assign busy      = |pending_q;

    // A result landing on an occupied holding register would mean pending tracking is broken
    assert property (@(posedge clk) disable iff (!rst_n)
        !(tag_v_q[ALU_LAT-1] && rsp_valid_q[tag_id_q[ALU_LAT-1]]));

    assert property (@(posedge clk) disable iff (!rst_n) $onehot0(req_ready));

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Bench for alu_req_arbiter: directed scenarios plus a randomized run against a
// pending/due-time reference model; the shared ALU is modelled as a 2-stage pipeline.
module tb_alu_req_arbiter;
    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [11:0] req_op;
    logic [3:0]  rsp_valid;
    logic [3:0]  rsp_ready;
    logic [31:0] rsp_data;
    logic [3:0]  rsp_carry;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [2:0]  alu_op;
    logic [7:0]  alu_out;
    logic        alu_carry;
    logic        busy;

    int checks;
    int errors;

    alu_req_arbiter #(.NREQ(4), .ALU_LAT(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_carry(rsp_carry),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_out(alu_out), .alu_carry(alu_carry),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [8:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                           input logic [2:0] op);
        case (op)
            3'd0:    return {1'b0, a} + {1'b0, b};
            3'd1:    return {1'b0, a} - {1'b0, b};
            3'd2:    return {1'b0, a & b};
            3'd3:    return {1'b0, a | b};
            3'd4:    return {1'b0, a ^ b};
            3'd5:    return {a, 1'b0};
            3'd6:    return {a[0], 1'b0, a[7:1]};
            default: return {1'b0, ~a};
        endcase
    endfunction

    // External ALU: samples at the issue edge, result valid two edges later
    logic [8:0] alu_s1, alu_s2;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_s1 <= '0;
            alu_s2 <= '0;
        end else begin
            alu_s1 <= alu_ref(alu_a, alu_b, alu_op);
            alu_s2 <= alu_s1;
        end
    end
    assign alu_out   = alu_s2[7:0];
    assign alu_carry = alu_s2[8];

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; req_valid = '0; rsp_ready = '0;
        req_a = '0; req_b = '0; req_op = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0; req_valid = 4'hF; rsp_ready = 4'hF;
        req_a = $urandom; req_b = $urandom; req_op = 12'($urandom);
        #1;
        checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
        checks++; if (rsp_valid !== 4'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0000", rsp_valid); end
        checks++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL reset_rsp_data: got %h want 0", rsp_data); end
        checks++; if (rsp_carry !== 4'b0) begin errors++; $display("FAIL reset_rsp_carry: got %b want 0000", rsp_carry); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if ({alu_op, alu_a, alu_b} !== 19'h0) begin errors++; $display("FAIL reset_alu_bus: got %h want 0", {alu_op, alu_a, alu_b}); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL reset_first_grant: got %b want 0001", req_ready); end
    endtask

    task automatic test_single_add();
        int lat;
        lat = -1;
        do_reset();
        @(negedge clk);
        req_valid = 4'b0001; req_a = 32'd200; req_b = 32'd100; req_op = 12'd0; rsp_ready = 4'b0;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL add_grant: got %b want 0001", req_ready); end
        checks++; if ({alu_op, alu_a, alu_b} !== {3'd0, 8'd200, 8'd100}) begin errors++; $display("FAIL add_alu_bus: got %h want %h", {alu_op, alu_a, alu_b}, {3'd0, 8'd200, 8'd100}); end
        for (int c = 1; c <= 8 && lat < 0; c++) begin
            @(negedge clk);
            req_valid = 4'b0;
            #1;
            if (rsp_valid[0] === 1'b1) lat = c;
        end
        checks++; if (lat != 3) begin errors++; $display("FAIL add_latency: got %0d want 3", lat); end
        checks++; if (rsp_data[7:0] !== 8'd44) begin errors++; $display("FAIL add_data: got %0d want 44", rsp_data[7:0]); end
        checks++; if (rsp_carry[0] !== 1'b1) begin errors++; $display("FAIL add_carry: got %b want 1", rsp_carry[0]); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL add_busy_held: got %b want 1", busy); end
        rsp_ready = 4'b0001;
        @(negedge clk);
        #1;
        checks++; if (rsp_valid !== 4'b0) begin errors++; $display("FAIL add_rsp_clear: got %b want 0000", rsp_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL add_busy_idle: got %b want 0", busy); end
    endtask

    task automatic test_sub_req2();
        int lat;
        lat = -1;
        do_reset();
        @(negedge clk);
        req_valid = 4'b0100; req_a = 32'h0005_0000; req_b = 32'h000A_0000; req_op = 12'h040; rsp_ready = 4'b0;
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL sub_grant: got %b want 0100", req_ready); end
        for (int c = 1; c <= 8 && lat < 0; c++) begin
            @(negedge clk);
            req_valid = 4'b0;
            #1;
            checks++; if ((rsp_valid & 4'b1011) !== 4'b0) begin errors++; $display("FAIL sub_other_valid: got %b want x0xx zero", rsp_valid); end
            if (rsp_valid[2] === 1'b1) lat = c;
        end
        checks++; if (lat != 3) begin errors++; $display("FAIL sub_latency: got %0d want 3", lat); end
        checks++; if (rsp_data[23:16] !== 8'hFB) begin errors++; $display("FAIL sub_data: got %h want fb", rsp_data[23:16]); end
        checks++; if (rsp_carry[2] !== 1'b1) begin errors++; $display("FAIL sub_borrow: got %b want 1", rsp_carry[2]); end
        rsp_ready = 4'b0100;
        @(negedge clk);
        #1;
        checks++; if (rsp_valid !== 4'b0) begin errors++; $display("FAIL sub_rsp_clear: got %b want 0000", rsp_valid); end
    endtask

    task automatic test_all_four();
        logic [31:0] a, b;
        logic [11:0] op;
        logic [3:0]  vmask, eg, er;
        logic [8:0]  r;
        int k;
        do_reset();
        a = $urandom; b = $urandom; op = 12'($urandom);
        vmask = 4'hF;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            req_valid = vmask; req_a = a; req_b = b; req_op = op; rsp_ready = 4'hF;
            #1;
            eg = (c < 4) ? 4'(1 << c) : 4'b0;
            er = (c >= 3 && c <= 6) ? 4'(1 << (c - 3)) : 4'b0;
            checks++; if (req_ready !== eg) begin errors++; $display("FAIL all4_grant c=%0d: got %b want %b", c, req_ready, eg); end
            if (c < 4) begin
                checks++; if ({alu_op, alu_a, alu_b} !== {op[3*c +: 3], a[8*c +: 8], b[8*c +: 8]}) begin errors++; $display("FAIL all4_alu_bus c=%0d: got %h want %h", c, {alu_op, alu_a, alu_b}, {op[3*c +: 3], a[8*c +: 8], b[8*c +: 8]}); end
            end else begin
                checks++; if ({alu_op, alu_a, alu_b} !== 19'h0) begin errors++; $display("FAIL all4_alu_idle c=%0d: got %h want 0", c, {alu_op, alu_a, alu_b}); end
            end
            checks++; if (rsp_valid !== er) begin errors++; $display("FAIL all4_rsp_valid c=%0d: got %b want %b", c, rsp_valid, er); end
            if (c >= 3 && c <= 6) begin
                k = c - 3;
                r = alu_ref(a[8*k +: 8], b[8*k +: 8], op[3*k +: 3]);
                checks++; if ({rsp_carry[k], rsp_data[8*k +: 8]} !== r) begin errors++; $display("FAIL all4_result req%0d: got %h want %h", k, {rsp_carry[k], rsp_data[8*k +: 8]}, r); end
            end
            vmask = vmask & ~eg;
        end
    endtask

    task automatic test_backpressure();
        int g0;
        g0 = 0;
        do_reset();
        @(negedge clk);
        req_valid = 4'b0010; req_a = 32'h0000_F011; req_b = 32'h0000_3C22; req_op = 12'h020; rsp_ready = 4'b1101;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_grant1: got %b want 0010", req_ready); end
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            req_valid = 4'b0011;
            #1;
            if (req_ready[0] === 1'b1) g0++;
            if (c >= 3) begin
                checks++; if (rsp_valid[1] !== 1'b1) begin errors++; $display("FAIL bp_held_valid c=%0d: got %b want 1", c, rsp_valid[1]); end
                checks++; if ({rsp_carry[1], rsp_data[15:8]} !== 9'h0CC) begin errors++; $display("FAIL bp_held_data c=%0d: got %h want 0cc", c, {rsp_carry[1], rsp_data[15:8]}); end
                checks++; if (req_ready[1] !== 1'b0) begin errors++; $display("FAIL bp_no_reissue c=%0d: got %b want 0", c, req_ready[1]); end
            end
            if (rsp_valid[0] === 1'b1) begin
                checks++; if ({rsp_carry[0], rsp_data[7:0]} !== 9'h033) begin errors++; $display("FAIL bp_req0_data c=%0d: got %h want 033", c, {rsp_carry[0], rsp_data[7:0]}); end
            end
        end
        checks++; if (g0 != 3) begin errors++; $display("FAIL bp_req0_served: got %0d grants want 3", g0); end
        @(negedge clk);
        rsp_ready = 4'hF;
        #1;
        checks++; if (rsp_valid[1] !== 1'b1) begin errors++; $display("FAIL bp_before_accept: got %b want 1", rsp_valid[1]); end
        @(negedge clk);
        #1;
        checks++; if (rsp_valid[1] !== 1'b0) begin errors++; $display("FAIL bp_after_accept: got %b want 0", rsp_valid[1]); end
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_reissue: got %b want 0010", req_ready); end
    endtask

    task automatic test_fairness();
        logic [3:0] eg;
        int n0, n3;
        n0 = 0; n3 = 0;
        do_reset();
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            req_valid = 4'b1001; rsp_ready = 4'hF;
            req_a = $urandom; req_b = $urandom; req_op = 12'($urandom);
            #1;
            eg = (c % 4 == 0) ? 4'b0001 : (c % 4 == 1) ? 4'b1000 : 4'b0000;
            checks++; if (req_ready !== eg) begin errors++; $display("FAIL fair_grant c=%0d: got %b want %b", c, req_ready, eg); end
            if (req_ready[0] === 1'b1) n0++;
            if (req_ready[3] === 1'b1) n3++;
        end
        checks++; if (n0 != 6 || n3 != 6) begin errors++; $display("FAIL fair_counts: got %0d/%0d want 6/6", n0, n3); end
    endtask

    task automatic test_reset_midflight();
        int lat;
        lat = -1;
        do_reset();
        @(negedge clk);
        req_valid = 4'b0011; rsp_ready = 4'hF; req_a = $urandom; req_b = $urandom; req_op = 12'($urandom);
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rmf_issue0: got %b want 0001", req_ready); end
        @(negedge clk);
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL rmf_issue1: got %b want 0010", req_ready); end
        @(negedge clk);
        req_valid = 4'b0; rst_n = 1'b0;
        #1;
        checks++; if ({req_ready, rsp_valid, rsp_carry, busy} !== 13'h0) begin errors++; $display("FAIL rmf_outputs_zero: got %h want 0", {req_ready, rsp_valid, rsp_carry, busy}); end
        checks++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL rmf_data_zero: got %h want 0", rsp_data); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1;
            checks++; if (rsp_valid !== 4'b0) begin errors++; $display("FAIL rmf_stale_valid c=%0d: got %b want 0000", c, rsp_valid); end
        end
        @(negedge clk);
        req_valid = 4'b0110; rsp_ready = 4'b0; req_a = 32'h0000_5A00; req_b = 32'h0000_0F00; req_op = 12'h018;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL rmf_lowest_first: got %b want 0010", req_ready); end
        for (int c = 1; c <= 8 && lat < 0; c++) begin
            @(negedge clk);
            req_valid = 4'b0;
            #1;
            if (rsp_valid[1] === 1'b1) lat = c;
        end
        checks++; if (lat != 3) begin errors++; $display("FAIL rmf_latency: got %0d want 3", lat); end
        checks++; if ({rsp_carry[1], rsp_data[15:8]} !== 9'h05F) begin errors++; $display("FAIL rmf_data: got %h want 05f", {rsp_carry[1], rsp_data[15:8]}); end
    endtask

    // Reference: per requester a pending flag, the cycle its result is due and the value
    task automatic test_random();
        logic [3:0]  mp, eg, ev;
        logic [8:0]  mres [4];
        int          mdue [4];
        int          mlast, gid, gs, j;
        logic [18:0] ealu;
        do_reset();
        mp = '0; mlast = 3;
        for (int i = 0; i < 4; i++) begin mdue[i] = 0; mres[i] = '0; end
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            req_valid = 4'($urandom); rsp_ready = 4'($urandom) | 4'($urandom);
            req_a = $urandom; req_b = $urandom; req_op = 12'($urandom);
            #1;
            for (int i = 0; i < 4; i++) ev[i] = mp[i] && (cyc >= mdue[i]);
            gid = -1;
            for (int k = 1; k <= 4; k++) begin
                j = (mlast + k) % 4;
                if (gid < 0 && req_valid[j] && !mp[j]) gid = j;
            end
            gs = (gid < 0) ? 0 : gid;
            eg = (gid < 0) ? 4'b0 : 4'(1 << gid);
            ealu = (gid < 0) ? 19'h0 : {req_op[3*gs +: 3], req_a[8*gs +: 8], req_b[8*gs +: 8]};
            checks++; if (req_ready !== eg) begin errors++; $display("FAIL rnd_grant cyc=%0d: got %b want %b", cyc, req_ready, eg); end
            checks++; if ({alu_op, alu_a, alu_b} !== ealu) begin errors++; $display("FAIL rnd_alu_bus cyc=%0d: got %h want %h", cyc, {alu_op, alu_a, alu_b}, ealu); end
            checks++; if (rsp_valid !== ev) begin errors++; $display("FAIL rnd_rsp_valid cyc=%0d: got %b want %b", cyc, rsp_valid, ev); end
            checks++; if (busy !== (|mp)) begin errors++; $display("FAIL rnd_busy cyc=%0d: got %b want %b", cyc, busy, |mp); end
            for (int i = 0; i < 4; i++) begin
                if (ev[i]) begin
                    checks++; if ({rsp_carry[i], rsp_data[8*i +: 8]} !== mres[i]) begin errors++; $display("FAIL rnd_result cyc=%0d req%0d: got %h want %h", cyc, i, {rsp_carry[i], rsp_data[8*i +: 8]}, mres[i]); end
                end
            end
            for (int i = 0; i < 4; i++) if (ev[i] && rsp_ready[i]) mp[i] = 1'b0;
            if (gid >= 0) begin
                mp[gid]   = 1'b1;
                mdue[gid] = cyc + 3;
                mres[gid] = alu_ref(req_a[8*gs +: 8], req_b[8*gs +: 8], req_op[3*gs +: 3]);
                mlast     = gid;
            end
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        rst_n = 1'b0; req_valid = '0; rsp_ready = '0;
        req_a = '0; req_b = '0; req_op = '0;
        test_reset();
        test_single_add();
        test_sub_req2();
        test_all_four();
        test_backpressure();
        test_fairness();
        test_reset_midflight();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/alu_req_arbiter.md
ALU_REQ_ARBITER -- requirements
Module: alu_req_arbiter

Interface
REQ-001 Parameter NREQ, 4, number of requesters; fixed at 4 for this release.
REQ-002 Parameter ALU_LAT, 2, edges from ALU input sampling to a valid alu_out/alu_carry.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  4  per-requester request valid.
REQ-006 req_ready  output  4  per-requester grant; handshake when req_valid[i] and req_ready[i] are both 1.
REQ-007 req_a, req_b  input  32 each  packed operands; byte i belongs to requester i.
REQ-008 req_op  input  12  packed 3-bit opcodes; bits [3i+2:3i] belong to requester i.
REQ-009 rsp_valid  output  4  per-requester result valid.
REQ-010 rsp_ready  input  4  per-requester result accept.
REQ-011 rsp_data  output  32  packed 8-bit results; byte i belongs to requester i.
REQ-012 rsp_carry  output  4  per-requester carry/borrow bit.
REQ-013 alu_a, alu_b  output  8 each  operands to the shared ALU.
REQ-014 alu_op  output  3  opcode to the shared ALU.
REQ-015 alu_out  input  8  ALU result.
REQ-016 alu_carry  input  1  ALU 9th result bit.
REQ-017 busy  output  1  1 when any request is in flight or any result is held.

Function
REQ-018 Each requester SHALL have at most one outstanding operation: pending[i] sets on the request handshake and clears on the rsp_valid[i]&rsp_ready[i] handshake.
REQ-019 Requester i is eligible when req_valid[i]=1 and pending[i]=0; a request cannot issue in the same cycle its previous result is accepted.
REQ-020 At most one req_ready bit SHALL be 1 per cycle, only for an eligible requester, and req_ready SHALL be combinational from req_valid and registered state.
REQ-021 Arbitration SHALL be round-robin: search starts at (last_grant+1) mod 4; last_grant updates only on a handshake; last_grant resets to 3, so requester 0 has first priority.
REQ-022 alu_a/alu_b/alu_op SHALL carry the granted requester's byte/opcode in the grant cycle; with no grant they SHALL be 0/0/3'b000.
REQ-023 A 2-entry tag shift register (valid + 2-bit id) SHALL track in-flight operations: stage 1 loads {grant, id} at the issue edge and stage 2 loads stage 1 at the following edge.
REQ-024 When stage 2 is valid, alu_out/alu_carry SHALL be captured into requester id's holding register at the next edge, and rsp_valid[id] SHALL set.
REQ-025 Latency: handshake in cycle T gives rsp_valid[i]=1 from cycle T+3; sustained throughput is one issue per cycle across requesters.
REQ-026 rsp_valid[i], rsp_data byte i and rsp_carry[i] SHALL hold stable until accepted, independent of other requesters' traffic.
REQ-027 rsp_valid[i] SHALL clear on the edge that completes its handshake.
REQ-028 A result arriving for a requester whose holding register is full is impossible by REQ-018; an assertion SHALL flag it.
REQ-029 The block SHALL not alter ALU data: rsp_data and rsp_carry equal alu_out and alu_carry as sampled.
REQ-030 busy = OR of the pending bits.

Reset
REQ-031 While rst_n=0, and asynchronously on assertion, the following SHALL be forced: pending, rsp_valid, tag valids, rsp_data, rsp_carry and req_ready all 0, and last_grant=3.
REQ-032 Reset during operation SHALL discard all in-flight and held results; no rsp_valid pulse SHALL occur for pre-reset requests.
REQ-033 After release, the first grant SHALL go to the lowest-index valid requester; the ALU shares rst_n.

Verification
REQ-034 Single ADD: req0 a=200, b=100, op=000 handshake at T -> rsp_valid[0] at T+3, rsp_data[7:0]=44, rsp_carry[0]=1.
REQ-035 SUB on req2: a=5, b=10, op=001 -> rsp byte 2 = 0xFB, rsp_carry[2]=1; other rsp_valid bits stay 0.
REQ-036 All four valid from reset with rsp_ready=4'hF -> grants 0,1,2,3 on consecutive cycles, results in order at T+3..T+6, ALU issue every cycle.
REQ-037 Backpressure: req1 XOR 0xF0^0x3C with rsp_ready[1]=0 for 10 cycles -> rsp byte 1 held at 0xCC, req_ready[1]=0 despite req_valid[1]=1, other requesters still served.
REQ-038 Fairness: req0 and req3 continuously valid with immediate rsp_ready -> grants never starve either; each is granted within 4 cycles of eligibility.
REQ-039 Reset mid-flight: rst_n low one cycle after two issues -> all outputs 0, no stale rsp_valid afterwards, and the next request completes normally with 3-cycle latency.
